// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Generates VGA raster timing from a pixel clock and clock enable, and drives
// the VGA pins with colour from one of three sources (host, colour bars, black).
//
// Ports:
//   iCLK, iRST_N          pixel clock, asynchronous active-low reset
//   iEN                   pixel clock enable; all state holds while low
//   iMode                 source select (0 host, 1 colour bars, 2/3 black),
//                         sampled only at the start of a frame
//   iRed/iGreen/iBlue     host colour, presented PIPE enabled cycles after
//                         the matching coordinate appears on oCoord_X/Y
//   oCoord_X/oCoord_Y     current raster coordinate (counter registers)
//   oReq                  current coordinate lies in the active area
//   oFrame_Start          one-cycle pulse while the coordinate is (0,0)
//   oVGA_R/G/B            pixel colour, zero outside the active area
//   oVGA_H_SYNC/V_SYNC    syncs, asserted level HS_POL/VS_POL
//   oVGA_BLANK            active-low blank
//   oVGA_SYNC             composite sync, tied low
module vga_timing_gen #(
   parameter int   H_ACT  = 640,
   parameter int   H_FP   = 16,
   parameter int   H_SYNC = 96,
   parameter int   H_BP   = 48,
   parameter int   V_ACT  = 480,
   parameter int   V_FP   = 10,
   parameter int   V_SYNC = 2,
   parameter int   V_BP   = 33,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0,
   parameter int   CW     = 10,
   parameter int   PIPE   = 2
) (
   input  logic          iCLK,
   input  logic          iRST_N,
   input  logic          iEN,
   input  logic [1:0]    iMode,
   input  logic [CW-1:0] iRed,
   input  logic [CW-1:0] iGreen,
   input  logic [CW-1:0] iBlue,
   output logic [11:0]   oCoord_X,
   output logic [11:0]   oCoord_Y,
   output logic          oReq,
   output logic          oFrame_Start,
   output logic [CW-1:0] oVGA_R,
   output logic [CW-1:0] oVGA_G,
   output logic [CW-1:0] oVGA_B,
   output logic          oVGA_H_SYNC,
   output logic          oVGA_V_SYNC,
   output logic          oVGA_BLANK,
   output logic          oVGA_SYNC
);

   localparam int H_TOTAL  = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACT + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACT + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int BAR_W    = H_ACT / 8;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

   // Everything the output register needs about one coordinate travels
   // together, so syncs, blank, bar index and source stay aligned.
   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [2:0] bar;
      logic [1:0] mode;
   } stage_t;

   localparam stage_t STAGE_RST = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL,
                                    bar: 3'd0, mode: 2'd0};

   logic [11:0] h, v;
   logic [11:0] hNext, vNext;
   logic        hWrap;
   logic        nextActive, nextOrigin;
   logic [1:0]  modeReg;
   stage_t      rawStage, dlyStage;
   logic [2:0]  barRgb;
   logic [CW-1:0] srcR, srcG, srcB;

   // Next raster position; the comparisons use 13 bits so a region ending
   // exactly at 4096 still compares correctly.
   always_comb begin
      hWrap      = (h == H_LAST);
      hNext      = hWrap ? 12'd0 : h + 12'd1;
      vNext      = v;
      if (hWrap) begin
         vNext = (v == V_LAST) ? 12'd0 : v + 12'd1;
      end
      nextActive = ({1'b0, hNext} < 13'(H_ACT)) && ({1'b0, vNext} < 13'(V_ACT));
      nextOrigin = (hNext == 12'd0) && (vNext == 12'd0);
   end

   // Raster counters plus the flags that describe the coordinate they hold.
   // Reset parks the counters on the last coordinate so the first enabled
   // edge lands on (0,0). The source mode is only sampled as a new frame
   // begins, so a frame never mixes sources.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         h            <= H_LAST;
         v            <= V_LAST;
         oReq         <= 1'b0;
         oFrame_Start <= 1'b0;
         modeReg      <= 2'd0;
      end else if (iEN) begin
         h            <= hNext;
         v            <= vNext;
         oReq         <= nextActive;
         oFrame_Start <= nextOrigin;
         if (nextOrigin) begin
            modeReg <= iMode;
         end
      end
   end

   assign oCoord_X = h;
   assign oCoord_Y = v;

   // Per-coordinate raw timing for the coordinate currently on oCoord.
   always_comb begin
      rawStage      = STAGE_RST;
      rawStage.de   = ({1'b0, h} < 13'(H_ACT)) && ({1'b0, v} < 13'(V_ACT));
      rawStage.hs   = (({1'b0, h} >= 13'(HS_START)) && ({1'b0, h} < 13'(HS_END)))
                      ? HS_POL : ~HS_POL;
      rawStage.vs   = (({1'b0, v} >= 13'(VS_START)) && ({1'b0, v} < 13'(VS_END)))
                      ? VS_POL : ~VS_POL;
      rawStage.bar  = 3'(h / 12'(BAR_W));
      rawStage.mode = modeReg;
   end

   // Delay line matching the host's colour latency; with PIPE=0 the raw
   // timing feeds the output register directly.
   generate
      if (PIPE == 0) begin : gNoPipe
         assign dlyStage = rawStage;
      end else begin : gPipe
         stage_t pipe [PIPE];

         // Shift register advancing one stage per enabled cycle.
         always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
               for (int i = 0; i < PIPE; i++) begin
                  pipe[i] <= STAGE_RST;
               end
            end else if (iEN) begin
               pipe[0] <= rawStage;
               for (int i = 1; i < PIPE; i++) begin
                  pipe[i] <= pipe[i-1];
               end
            end
         end

         assign dlyStage = pipe[PIPE-1];
      end
   endgenerate

   // Colour bar lookup (bits R,G,B) and source selection for the delayed
   // coordinate.
   always_comb begin
      barRgb = 3'b000;
      case (dlyStage.bar)
         3'd0:    barRgb = 3'b111;
         3'd1:    barRgb = 3'b110;
         3'd2:    barRgb = 3'b011;
         3'd3:    barRgb = 3'b010;
         3'd4:    barRgb = 3'b101;
         3'd5:    barRgb = 3'b100;
         3'd6:    barRgb = 3'b001;
         default: barRgb = 3'b000;
      endcase
      srcR = '0;
      srcG = '0;
      srcB = '0;
      case (dlyStage.mode)
         2'd0: begin
            srcR = iRed;
            srcG = iGreen;
            srcB = iBlue;
         end
         2'd1: begin
            srcR = {CW{barRgb[2]}};
            srcG = {CW{barRgb[1]}};
            srcB = {CW{barRgb[0]}};
         end
         default: begin
            srcR = '0;
            srcG = '0;
            srcB = '0;
         end
      endcase
   end

   // Output register: one enabled cycle after the delay line, so pins trail
   // the coordinate by PIPE+1 enabled cycles with everything aligned.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oVGA_R      <= '0;
         oVGA_G      <= '0;
         oVGA_B      <= '0;
         oVGA_BLANK  <= 1'b0;
         oVGA_H_SYNC <= ~HS_POL;
         oVGA_V_SYNC <= ~VS_POL;
      end else if (iEN) begin
         oVGA_R      <= dlyStage.de ? srcR : '0;
         oVGA_G      <= dlyStage.de ? srcG : '0;
         oVGA_B      <= dlyStage.de ? srcB : '0;
         oVGA_BLANK  <= dlyStage.de;
         oVGA_H_SYNC <= dlyStage.hs;
         oVGA_V_SYNC <= dlyStage.vs;
      end
   end

   assign oVGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Bench for vga_timing_gen on a tiny 15x8 raster with PIPE=2. A second
// instance with inverted sync polarities shares all inputs. Expected pin
// values are pushed to a queue as each coordinate is produced by the bench's
// own raster model and popped when the pins should show them.
module tb_vga_timing_gen;

   localparam int H_TOTAL = 15;
   localparam int V_TOTAL = 8;

   logic       iCLK = 1'b0;
   logic       iRST_N;
   logic       iEN;
   logic [1:0] iMode;
   logic [9:0] iRed, iGreen, iBlue;

   logic [11:0] oCoord_X, oCoord_Y;
   logic        oReq, oFrame_Start;
   logic [9:0]  oVGA_R, oVGA_G, oVGA_B;
   logic        oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC;

   logic [11:0] pCoord_X, pCoord_Y;
   logic        pReq, pFrame_Start;
   logic [9:0]  pVGA_R, pVGA_G, pVGA_B;
   logic        pVGA_H_SYNC, pVGA_V_SYNC, pVGA_BLANK, pVGA_SYNC;

   vga_timing_gen #(
      .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .PIPE(2)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iMode(iMode),
      .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
      .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y),
      .oReq(oReq), .oFrame_Start(oFrame_Start),
      .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
      .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC),
      .oVGA_BLANK(oVGA_BLANK), .oVGA_SYNC(oVGA_SYNC)
   );

   vga_timing_gen #(
      .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .PIPE(2)
   ) dutP (
      .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iMode(iMode),
      .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
      .oCoord_X(pCoord_X), .oCoord_Y(pCoord_Y),
      .oReq(pReq), .oFrame_Start(pFrame_Start),
      .oVGA_R(pVGA_R), .oVGA_G(pVGA_G), .oVGA_B(pVGA_B),
      .oVGA_H_SYNC(pVGA_H_SYNC), .oVGA_V_SYNC(pVGA_V_SYNC),
      .oVGA_BLANK(pVGA_BLANK), .oVGA_SYNC(pVGA_SYNC)
   );

   // Pixel clock, 10 time units per cycle.
   always #5 iCLK = ~iCLK;

   // pins = {blank, hsync, vsync, R, G, B}
   typedef struct {
      int         x;
      int         y;
      logic [32:0] pins;
   } pinExp_t;

   localparam logic [32:0] PINS_RST = {1'b0, 1'b1, 1'b1, 30'd0};

   pinExp_t    expQ[$];
   pinExp_t    curPin;
   int         hostX[$];
   int         hostY[$];
   int         mh, mv;
   logic [1:0] mMode;
   int         compared   = 0;
   int         mismatched = 0;
   int         edgeCount  = 0;

   // Colour bars as {R,G,B} bits: white, yellow, cyan, green, magenta, red,
   // blue, black.
   logic [2:0] barRgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                              3'b101, 3'b100, 3'b001, 3'b000};

   // Expected pin values for a coordinate under a given captured mode.
   function automatic pinExp_t expFor(input int x, input int y, input logic [1:0] mode);
      pinExp_t    e;
      logic       de, hs, vs;
      logic [9:0] r, g, b;
      logic [2:0] bits;
      de = (x < 8) && (y < 4);
      hs = !((x >= 10) && (x < 13));
      vs = !((y >= 5) && (y < 7));
      r = '0; g = '0; b = '0;
      if (de) begin
         if (mode == 2'd0) begin
            r = 10'(x);
            g = 10'(y);
            b = 10'(x + y + 100);
         end else if (mode == 2'd1) begin
            bits = barRgb[x];
            r = {10{bits[2]}};
            g = {10{bits[1]}};
            b = {10{bits[0]}};
         end
      end
      e.x = x;
      e.y = y;
      e.pins = {de, hs, vs, r, g, b};
      return e;
   endfunction

   // Host: drives the colour of the coordinate seen two enabled cycles ago.
   task automatic driveHost();
      if (hostX[0] < 0) begin
         iRed = '0; iGreen = '0; iBlue = '0;
      end else begin
         iRed   = 10'(hostX[0]);
         iGreen = 10'(hostY[0]);
         iBlue  = 10'(hostX[0] + hostY[0] + 100);
      end
   endtask

   // Model state matching a design held in reset: parked on (14,7), the
   // two cleared delay stages and the parked coordinate already in flight.
   task automatic resetModel();
      pinExp_t r;
      mh = H_TOTAL - 1;
      mv = V_TOTAL - 1;
      mMode = 2'd0;
      r.x = -1; r.y = -1; r.pins = PINS_RST;
      expQ.delete();
      expQ.push_back(r);
      expQ.push_back(r);
      expQ.push_back(expFor(mh, mv, 2'd0));
      curPin = r;
      hostX = '{-1, -1, H_TOTAL - 1};
      hostY = '{-1, -1, V_TOTAL - 1};
      driveHost();
   endtask

   // One clock cycle with the given enable; advances the model on enabled
   // edges and scores coordinate, flags and pins of both instances.
   task automatic runCycle(input logic en);
      logic        expReq, expFs;
      logic [32:0] actPins;
      iEN = en;
      @(posedge iCLK);
      #1;
      if (en) begin
         edgeCount++;
         if (mh == H_TOTAL - 1) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
         if (mh == 0 && mv == 0) mMode = iMode;
         expQ.push_back(expFor(mh, mv, mMode));
         hostX.push_back(mh);
         hostY.push_back(mv);
         void'(hostX.pop_front());
         void'(hostY.pop_front());
         driveHost();
         curPin = expQ.pop_front();
      end
      expReq = (mh < 8) && (mv < 4);
      expFs  = (mh == 0) && (mv == 0);
      compared++;
      if ({oCoord_X, oCoord_Y} !== {12'(mh), 12'(mv)}) begin
         mismatched++;
         $display("[TB] FAIL coord: got (%0d,%0d) expected (%0d,%0d)", oCoord_X, oCoord_Y, mh, mv);
      end
      compared++;
      if ({oReq, oFrame_Start} !== {expReq, expFs}) begin
         mismatched++;
         $display("[TB] FAIL req/frameStart at (%0d,%0d): got %b%b expected %b%b",
                  mh, mv, oReq, oFrame_Start, expReq, expFs);
      end
      actPins = {oVGA_BLANK, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_R, oVGA_G, oVGA_B};
      compared++;
      if (actPins !== curPin.pins) begin
         mismatched++;
         $display("[TB] FAIL pins for (%0d,%0d): got %h expected %h", curPin.x, curPin.y, actPins, curPin.pins);
      end
      compared++;
      if ({pVGA_H_SYNC, pVGA_V_SYNC, oVGA_SYNC} !== {~curPin.pins[31:30], 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL polarity/compositeSync: got %b%b%b expected %b0",
                  pVGA_H_SYNC, pVGA_V_SYNC, oVGA_SYNC, ~curPin.pins[31:30]);
      end
   endtask

   // Reset values on both instances, then release.
   task automatic test_reset();
      logic [32:0] actPins;
      $display("[TB] test_reset");
      iRST_N = 1'b0;
      iEN    = 1'b1;
      iMode  = 2'd0;
      resetModel();
      repeat (3) @(posedge iCLK);
      #1;
      compared++;
      if ({oCoord_X, oCoord_Y, oReq, oFrame_Start} !== {12'd14, 12'd7, 2'b00}) begin
         mismatched++;
         $display("[TB] FAIL resetCoord: got (%0d,%0d) %b%b expected (14,7) 00", oCoord_X, oCoord_Y, oReq, oFrame_Start);
      end
      actPins = {oVGA_BLANK, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_R, oVGA_G, oVGA_B};
      compared++;
      if (actPins !== PINS_RST) begin
         mismatched++;
         $display("[TB] FAIL resetPins: got %h expected %h", actPins, PINS_RST);
      end
      compared++;
      if ({pVGA_H_SYNC, pVGA_V_SYNC, pVGA_BLANK} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL resetPolarity: got %b%b%b expected 000", pVGA_H_SYNC, pVGA_V_SYNC, pVGA_BLANK);
      end
      iRST_N = 1'b1;
      edgeCount = 0;
   endtask

   // First frame in host mode: frame-start positions, active-line shape and
   // hsync latency.
   task automatic test_frame();
      int fsEdges[$];
      int runLen = 0;
      int runs = 0;
      int firstHsLow = -1;
      int firstX10 = -1;
      $display("[TB] test_frame");
      for (int i = 0; i < 121; i++) begin
         runCycle(1'b1);
         if (oFrame_Start) fsEdges.push_back(edgeCount);
         if (firstX10 < 0 && mh == 10) firstX10 = edgeCount;
         if (firstHsLow < 0 && oVGA_H_SYNC == 1'b0) firstHsLow = edgeCount;
         if (edgeCount <= 120) begin
            if (oReq) runLen++;
            else begin
               if (runLen > 0) begin
                  runs++;
                  compared++;
                  if (runLen != 8) begin
                     mismatched++;
                     $display("[TB] FAIL reqRunLength: got %0d expected 8", runLen);
                  end
               end
               runLen = 0;
            end
         end
      end
      compared++;
      if (runs != 4) begin
         mismatched++;
         $display("[TB] FAIL reqLines: got %0d expected 4", runs);
      end
      compared++;
      if (fsEdges.size() != 2 || fsEdges[0] != 1 || fsEdges[1] != 121) begin
         mismatched++;
         $display("[TB] FAIL frameStartEdges: got %0d pulses (first %0d) expected 2 at 1 and 121",
                  fsEdges.size(), (fsEdges.size() > 0) ? fsEdges[0] : -1);
      end
      compared++;
      if (firstX10 != 11 || firstHsLow != 14) begin
         mismatched++;
         $display("[TB] FAIL hsyncLatency: x=10 at edge %0d hsync low at edge %0d expected 11 and 14", firstX10, firstHsLow);
      end
   endtask

   // Mode change mid-frame only takes effect on the next frame; that frame
   // shows the eight colour bars on line 0.
   task automatic test_mode_switch();
      int  barHits = 0;
      logic gotFs = 1'b0;
      logic [29:0] expRgb;
      logic [2:0]  bits;
      $display("[TB] test_mode_switch");
      repeat (60) runCycle(1'b1);
      iMode = 2'd1;
      for (int i = 0; i < 200 && !gotFs; i++) begin
         runCycle(1'b1);
         gotFs = oFrame_Start;
      end
      compared++;
      if (!gotFs) begin
         mismatched++;
         $display("[TB] FAIL modeFrameStart: got no frame start expected one within 200 cycles");
      end
      for (int i = 0; i < 120; i++) begin
         runCycle(1'b1);
         if (curPin.y == 0 && curPin.x >= 0 && curPin.x < 8) begin
            bits = barRgb[curPin.x];
            expRgb = {{10{bits[2]}}, {10{bits[1]}}, {10{bits[0]}}};
            barHits++;
            compared++;
            if ({oVGA_R, oVGA_G, oVGA_B} !== expRgb) begin
               mismatched++;
               $display("[TB] FAIL bar%0d: got %h/%h/%h expected %h", curPin.x, oVGA_R, oVGA_G, oVGA_B, expRgb);
            end
         end
      end
      compared++;
      if (barHits != 8) begin
         mismatched++;
         $display("[TB] FAIL barCount: got %0d expected 8", barHits);
      end
      iMode = 2'd0;
   endtask

   // Alternating enable: a frame still spans 120 enabled edges with 32
   // active coordinates, and stalled cycles hold everything.
   task automatic test_stall();
      logic started = 1'b0;
      logic done = 1'b0;
      int   enCount = 0;
      int   reqCount = 0;
      logic en;
      $display("[TB] test_stall");
      for (int i = 0; i < 700 && !done; i++) begin
         en = (i % 2 == 0);
         runCycle(en);
         if (en) begin
            if (started) begin
               enCount++;
               if (oReq) reqCount++;
               if (oFrame_Start) done = 1'b1;
            end else if (oFrame_Start) begin
               started = 1'b1;
            end
         end
      end
      compared++;
      if (!done || enCount != 120) begin
         mismatched++;
         $display("[TB] FAIL stallFrameLength: got %0d enabled edges expected 120", enCount);
      end
      compared++;
      if (reqCount != 32) begin
         mismatched++;
         $display("[TB] FAIL stallReqCount: got %0d expected 32", reqCount);
      end
      iEN = 1'b1;
   endtask

   // Reset asserted between clock edges at (5,2) takes effect at once.
   task automatic test_async_reset();
      logic        hit = 1'b0;
      logic [32:0] actPins;
      $display("[TB] test_async_reset");
      for (int i = 0; i < 200 && !hit; i++) begin
         runCycle(1'b1);
         hit = (mh == 5 && mv == 2);
      end
      compared++;
      if (!hit) begin
         mismatched++;
         $display("[TB] FAIL asyncReach: got no (5,2) expected it within 200 cycles");
      end
      #3;
      iRST_N = 1'b0;
      #1;
      compared++;
      if ({oCoord_X, oCoord_Y, oReq, oFrame_Start} !== {12'd14, 12'd7, 2'b00}) begin
         mismatched++;
         $display("[TB] FAIL asyncResetCoord: got (%0d,%0d) %b%b expected (14,7) 00", oCoord_X, oCoord_Y, oReq, oFrame_Start);
      end
      actPins = {oVGA_BLANK, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_R, oVGA_G, oVGA_B};
      compared++;
      if (actPins !== PINS_RST) begin
         mismatched++;
         $display("[TB] FAIL asyncResetPins: got %h expected %h", actPins, PINS_RST);
      end
      compared++;
      if ({pVGA_H_SYNC, pVGA_V_SYNC} !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL asyncResetPolarity: got %b%b expected 00", pVGA_H_SYNC, pVGA_V_SYNC);
      end
      resetModel();
      @(posedge iCLK);
      #2;
      iRST_N = 1'b1;
      runCycle(1'b1);
      compared++;
      if ({oCoord_X, oCoord_Y, oFrame_Start} !== {24'd0, 1'b1}) begin
         mismatched++;
         $display("[TB] FAIL firstAfterRelease: got (%0d,%0d) fs=%b expected (0,0) fs=1", oCoord_X, oCoord_Y, oFrame_Start);
      end
      repeat (130) runCycle(1'b1);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_mode_switch();
      test_stall();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
